alu_stream: RTL and testbench
=============================

# alu_stream

Streaming, handshaked wrapper around the 8-bit signed ALU. It consumes operand beats (A, B, sel) on a valid/ready input port. Each beat is computed in one registered pipeline stage, and results are queued in an output FIFO presented on a valid/ready result port. It is the hardware counterpart of the file-driven stimulus/capture bench: an upstream producer pushes operand triples, and a downstream consumer drains (C, Z) results in order with back-pressure.

## Interface
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  8  signed operand.
- B  in  8  signed operand.
- sel  in  3  opcode.
- out_valid  out  1  result at FIFO head.
- out_ready  in  1  consumer takes the head this cycle.
- C  out  8  signed result (FIFO head).
- Z  out  1  C == 0 (FIFO head).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

One clock (clk); reset is synchronous and active-high (rst).

## Operation
- Accept: an accept event occurs when in_valid && in_ready at a rising edge. A, B and sel are registered into the stage register, and stage_v is set.
- Stage: with stage_v=1, the combinational ALU result is pushed into the FIFO on the next edge, and stage_v clears unless a new accept occurs on that same edge.
- Opcodes (all 8-bit two's complement, wrap modulo 256):
  - 000: A+B
  - 001: A−B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: (A<B signed) ? 1 : 0
  - 110: A>>>B[2:0] (arithmetic)
  - 111: low 8 bits of A×B (signed)
- Z is computed from the 8-bit result and stored alongside C, so the FIFO width is 9 bits (10 with the macro).
- in_ready = (count + stage_v) < DEPTH. This is conservative and ignores a same-cycle pop, which guarantees the stage can always push.
- Pop: occurs when out_valid && out_ready. The head advances, and C/Z show the next entry or hold their last value when empty.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Outputs not gated: C and Z are don't-care when out_valid=0, but they must not be X after reset.

## Timing
- Reset values: in_ready=1, out_valid=0, C=0, Z=0 (register reset only), count=0, stage_v=0. The FIFO pointers clear; reset holds as long as rst=1.
- Latency: accept at edge N → FIFO push at edge N+1 → out_valid=1 during cycle after N+1. Minimum 2 edges from accept to out_valid.
- Throughput: 1 beat/cycle sustained while out_ready=1 and DEPTH ≥ 2.
- Simultaneous push and pop: count unchanged, pointers both advance, including when full (pop frees the slot the push uses). Push into an empty FIFO with out_ready=1: the pop does not occur that edge, because out_valid was 0.
- Full: count=DEPTH → in_ready=0. Also in_ready=0 when count=DEPTH−1 and stage_v=1.
- Empty: out_valid=0; out_ready is ignored.
- Pointer wrap: log2(DEPTH)-bit pointers wrap DEPTH−1 → 0 silently; count distinguishes full from empty.
- Reset mid-operation: stage contents and all queued results are discarded; the first post-reset accept behaves as in the latency rule above.
- in_valid deassertion does not disturb an in-flight stage beat.

## Configuration
- ALU_STREAM_OVF_EN defined:
  - Adds output port V (1 bit, reset 0), queued with C/Z.
  - V = signed overflow for opcodes 000/001: operand signs agree (add) or differ (sub) and the result sign differs from A. V=0 for all other opcodes.
- Undefined: no V port; the FIFO is 9 bits wide. All other behaviour is identical.

## Test plan
- Basic ops, out_ready=1: accept A=5, B=3 with each sel 0..7 → C = 8, 2, 1, 7, 6, 0, 0, 15 in order. Z=1 only for sel=5 and sel=6. out_valid first rises 2 edges after the first accept.
- Wrap/overflow: A=−128, B=1, sel=001 → C=127, Z=0, and V=1 when ALU_STREAM_OVF_EN is defined. A=100, B=100, sel=000 → C=−56 (V=1).
- Back-pressure with DEPTH=4, out_ready=0:
  - Stream 6 beats → exactly 4 accepted; in_ready drops after the 4th accept; count=4.
  - Then assert out_ready=1 → results drain in order, and the remaining 2 beats are accepted with no loss.
- Simultaneous push/pop at full: count=4, stage_v=0, in_valid=1, out_ready=1 → pop the head on that edge; count stays 4 after the deferred push; ordering preserved.
- Zero result: A=7, B=−7, sel=000 → C=0, Z=1. Also A=−1, B=3, sel=110 → C=−1, Z=0.
- Reset mid-stream: 3 results queued plus 1 in stage, assert rst for 1 cycle → count=0, out_valid=0, in_ready=1. Then accept A=2, B=2, sel=000 → C=4 after 2 edges.

Source files
------------

// File: rtl/alu_stream.sv
// alu_stream: handshaked streaming wrapper around the 8-bit signed ALU.
// One registered operand stage feeds a DEPTH-entry result FIFO of (C, Z).
// Optional feature macro: ALU_STREAM_OVF_EN adds a queued signed-overflow
// flag V for add/sub; without it the FIFO carries only C and Z.
module alu_stream #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              A,
  input  logic [7:0]              B,
  input  logic [2:0]              sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              C,
  output logic                    Z,
`ifdef ALU_STREAM_OVF_EN
  output logic                    V,
`endif
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] c;
    logic       z;
`ifdef ALU_STREAM_OVF_EN
    logic       v;
`endif
  } res_t;

  // stage register
  logic          stage_v;
  logic [7:0]    st_a, st_b;
  logic [2:0]    st_sel;

  // fifo state
  res_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nx;
  res_t          head;
  res_t          wdata;
  logic          accept, push, pop;

  logic [7:0]    alu;
  logic [15:0]   prod;

  // Readiness counts the stage beat as already occupying a slot, so the
  // stage can always push next edge without checking for space.
  assign in_ready  = ({1'b0, count} + {{CW{1'b0}}, stage_v}) < FULL;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign push      = stage_v;
  assign pop       = out_valid && out_ready;
  assign rptr_nx   = rptr + AW'(1);

  assign prod = $signed(st_a) * $signed(st_b);

  // ALU on the staged operands; everything wraps modulo 256
  always_comb begin
    alu = '0;
    case (st_sel)
      3'd0: alu = st_a + st_b;
      3'd1: alu = st_a - st_b;
      3'd2: alu = st_a & st_b;
      3'd3: alu = st_a | st_b;
      3'd4: alu = st_a ^ st_b;
      3'd5: alu = {7'd0, ($signed(st_a) < $signed(st_b))};
      3'd6: alu = $signed(st_a) >>> st_b[2:0];
      3'd7: alu = prod[7:0];
      default: alu = '0;
    endcase
  end

  // Result entry written into the FIFO: value, zero flag (and overflow)
  always_comb begin
    wdata   = '0;
    wdata.c = alu;
    wdata.z = (alu == 8'd0);
`ifdef ALU_STREAM_OVF_EN
    // overflow only meaningful for add/sub: result sign departs from A
    if (st_sel == 3'd0)
      wdata.v = (st_a[7] == st_b[7]) && (alu[7] != st_a[7]);
    else if (st_sel == 3'd1)
      wdata.v = (st_a[7] != st_b[7]) && (alu[7] != st_a[7]);
`endif
  end

  // Operand stage: capture on accept, otherwise drain into the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v <= 1'b0;
      st_a    <= '0;
      st_b    <= '0;
      st_sel  <= '0;
    end else begin
      stage_v <= accept;
      if (accept) begin
        st_a   <= A;
        st_b   <= B;
        st_sel <= sel;
      end
    end
  end

  // FIFO storage; contents need no reset since the head is registered
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally, count tells full/empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr_nx;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered head: tracks the next entry, holds last value when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (pop) begin
      if (count > CW'(1)) head <= mem[rptr_nx];
      else if (push)      head <= wdata;
    end else if (count == '0 && push) begin
      head <= wdata;
    end
  end

  assign C = head.c;
  assign Z = head.z;
`ifdef ALU_STREAM_OVF_EN
  assign V = head.v;
`endif

endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: directed, self-checking bench for alu_stream (DEPTH=4).
module tb_alu_stream;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] C;
  logic       Z;
`ifdef ALU_STREAM_OVF_EN
  logic       V;
`endif
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  alu_stream #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .Z(Z),
`ifdef ALU_STREAM_OVF_EN
    .V(V),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; sel = '0;
    step; step;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (C !== 8'd0) begin errors++; $display("FAIL reset_C: got %h expected 00", C); end
    checks++; if (Z !== 1'b0) begin errors++; $display("FAIL reset_Z: got %b expected 0", Z); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
`ifdef ALU_STREAM_OVF_EN
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL reset_V: got %b expected 0", V); end
`endif
    rst = 1'b0;
    step;
  endtask

  // A=5, B=3 through every opcode, consumer always ready
  task automatic test_basic_ops;
    logic [7:0] exp_c [8];
    logic       exp_z [8];
    int nacc, npop;
    exp_c = '{8'd8, 8'd2, 8'd1, 8'd7, 8'd6, 8'd0, 8'd0, 8'd15};
    exp_z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    nacc = 0; npop = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; A = 8'd5; B = 8'd3; sel = 3'(cyc);
      end else in_valid = 1'b0;
      if (cyc == 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid %b expected 0", out_valid); end
      end
      if (cyc == 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b expected 1", out_valid); end
      end
      if (in_valid && in_ready) nacc++;
      if (out_valid && out_ready) begin
        if (npop < 8) begin
          checks++; if (C !== exp_c[npop]) begin errors++; $display("FAIL basic_C[%0d]: got %0d expected %0d", npop, C, exp_c[npop]); end
          checks++; if (Z !== exp_z[npop]) begin errors++; $display("FAIL basic_Z[%0d]: got %b expected %b", npop, Z, exp_z[npop]); end
        end
        npop++;
      end
      step;
    end
    checks++; if (nacc != 8) begin errors++; $display("FAIL basic_accepts: got %0d expected 8", nacc); end
    checks++; if (npop != 8) begin errors++; $display("FAIL basic_pops: got %0d expected 8", npop); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count_end: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  // Single beats covering wrap, overflow, zero, shift, compare, multiply
  task automatic test_wrap_zero;
    logic [7:0] va [10];
    logic [7:0] vb [10];
    logic [2:0] vs [10];
    logic [7:0] ec [10];
    logic       ez [10];
    logic       ev [10];
    va = '{8'h80, 8'h64, 8'h9C, 8'h80, 8'h07, 8'hFF, 8'hFD, 8'hFD, 8'h80, 8'h02};
    vb = '{8'h01, 8'h64, 8'h9C, 8'hFF, 8'hF9, 8'h03, 8'h02, 8'h05, 8'h0F, 8'hFD};
    vs = '{3'd1,  3'd0,  3'd0,  3'd1,  3'd0,  3'd6,  3'd5,  3'd7,  3'd6,  3'd5};
    ec = '{8'h7F, 8'hC8, 8'h38, 8'h81, 8'h00, 8'hFF, 8'h01, 8'hF1, 8'hFF, 8'h00};
    ez = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    ev = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; A = va[i]; B = vb[i]; sel = vs[i];
      step;
      in_valid = 1'b0;
      step;
      checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL vec_valid[%0d]: out_valid %b count %0d expected 1/1", i, out_valid, count); end
      checks++; if (C !== ec[i]) begin errors++; $display("FAIL vec_C[%0d]: got %h expected %h", i, C, ec[i]); end
      checks++; if (Z !== ez[i]) begin errors++; $display("FAIL vec_Z[%0d]: got %b expected %b", i, Z, ez[i]); end
`ifdef ALU_STREAM_OVF_EN
      checks++; if (V !== ev[i]) begin errors++; $display("FAIL vec_V[%0d]: got %b expected %b", i, V, ev[i]); end
`else
      if (ev[i] === 1'bx) $display("unexpected vector table content");
`endif
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL vec_drain[%0d]: out_valid %b count %0d expected 0/0", i, out_valid, count); end
    end
  endtask

  // Six beats into a stalled consumer, then release and drain
  task automatic test_backpressure;
    int nacc, npop;
    nacc = 0; npop = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = 1'b1; A = 8'(nacc + 1); B = 8'd10; sel = 3'd0;
      if (in_valid && in_ready) nacc++;
      step;
      if (nacc == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop[%0d]: got %b expected 0", cyc, in_ready); end
      end
    end
    checks++; if (nacc != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", nacc); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", count); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (nacc < 6) begin
        in_valid = 1'b1; A = 8'(nacc + 1); B = 8'd10; sel = 3'd0;
      end else in_valid = 1'b0;
      if (in_valid && in_ready) nacc++;
      if (out_valid && out_ready) begin
        checks++; if (C !== 8'(11 + npop)) begin errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", npop, C, 11 + npop); end
        npop++;
      end
      step;
    end
    in_valid = 1'b0;
    checks++; if (nacc != 6) begin errors++; $display("FAIL bp_total_accepted: got %0d expected 6", nacc); end
    checks++; if (npop != 6) begin errors++; $display("FAIL bp_total_popped: got %0d expected 6", npop); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_count_end: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  // Full FIFO, pop one while a beat waits; the deferred push refills it
  task automatic test_full_pushpop;
    int nacc, npop;
    nacc = 0; npop = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (nacc < 4) begin
        in_valid = 1'b1; A = 8'(20 + nacc); B = 8'd0; sel = 3'd0;
      end else in_valid = 1'b0;
      if (in_valid && in_ready) nacc++;
      step;
    end
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state: count %0d in_ready %b expected 4/0", count, in_ready); end
    in_valid = 1'b1; A = 8'd24; B = 8'd0; sel = 3'd0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || C !== 8'd20) begin errors++; $display("FAIL full_head: out_valid %b C %0d expected 1/20", out_valid, C); end
    step;
    out_ready = 1'b0;
    checks++; if (count !== 3'd3 || C !== 8'd21 || in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: count %0d C %0d in_ready %b expected 3/21/1", count, C, in_ready); end
    step;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL full_stage_hold: in_ready %b count %0d expected 0/3", in_ready, count); end
    step;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_refill: count %0d in_ready %b expected 4/0", count, in_ready); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (out_valid && out_ready) begin
        checks++; if (C !== 8'(21 + npop)) begin errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", npop, C, 21 + npop); end
        npop++;
      end
      step;
    end
    checks++; if (npop != 4) begin errors++; $display("FAIL full_popped: got %0d expected 4", npop); end
    out_ready = 1'b0;
  endtask

  // Reset with three queued results and one staged beat
  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; A = 8'(30 + i); B = 8'd1; sel = 3'd0;
      step;
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_precount: got %0d expected 3", count); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: count %0d out_valid %b in_ready %b expected 0/0/1", count, out_valid, in_ready); end
    step;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_stage_flushed: count %0d out_valid %b expected 0/0", count, out_valid); end
    in_valid = 1'b1; A = 8'd2; B = 8'd2; sel = 3'd0;
    step;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_latency_early: out_valid %b expected 0", out_valid); end
    step;
    checks++; if (out_valid !== 1'b1 || C !== 8'd4 || count !== 3'd1) begin errors++; $display("FAIL mid_first_result: out_valid %b C %0d count %0d expected 1/4/1", out_valid, C, count); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_ops;
    test_wrap_zero;
    test_backpressure;
    test_full_pushpop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
